// File: rtl/lzrw1_item_unpacker.sv
// Splits a raw LZRW1 byte stream (16-bit control word + up to ITEMS_PER_GROUP items)
// into one 16-bit item per transfer with a literal/copy flag for the decompressor.
module lzrw1_item_unpacker #(
  parameter int ITEMS_PER_GROUP = 16,
  parameter bit CW_MSB_FIRST    = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] item_data,
  output logic        item_flag,
  output logic        item_valid,
  input  logic        dec_busy,
  output logic        stream_done,
  output logic        format_error
);

  localparam logic [2:0] CW_LO   = 3'd0;
  localparam logic [2:0] CW_HI   = 3'd1;
  localparam logic [2:0] ITEM_B0 = 3'd2;
  localparam logic [2:0] ITEM_B1 = 3'd3;
  localparam logic [2:0] PRESENT = 3'd4;
  localparam logic [2:0] HOLDOFF = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;

  localparam logic [3:0] LAST_IDX = 4'(ITEMS_PER_GROUP - 1);

  logic [2:0]  state;
  logic [15:0] cw;
  logic [3:0]  item_idx;
  logic        last_seen;
  logic        accept;
  logic [3:0]  sel_idx;
  logic        cw_bit;

  // in_ready is gated by reset so every output reads 0 while reset is held low
  assign in_ready     = reset && ((state == CW_LO) || (state == CW_HI) ||
                                  (state == ITEM_B0) || (state == ITEM_B1));
  assign item_valid   = (state == PRESENT);
  assign stream_done  = (state == HOLDOFF) && last_seen;
  assign format_error = (state == ERROR);
  assign accept       = in_valid && in_ready;
  assign sel_idx      = CW_MSB_FIRST ? (4'd15 - item_idx) : item_idx;
  assign cw_bit       = cw[sel_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= CW_LO;
      cw        <= 16'h0000;
      item_idx  <= 4'd0;
      last_seen <= 1'b0;
      item_data <= 16'h0000;
      item_flag <= 1'b0;
    end else begin
      case (state)
        CW_LO: begin
          if (accept) begin
            if (in_last) begin
              state <= ERROR;
            end else begin
              cw[7:0] <= in_byte;
              state   <= CW_HI;
            end
          end
        end
        CW_HI: begin
          if (accept) begin
            if (in_last) begin
              state <= ERROR;
            end else begin
              cw[15:8] <= in_byte;
              item_idx <= 4'd0;
              state    <= ITEM_B0;
            end
          end
        end
        ITEM_B0: begin
          if (accept) begin
            item_flag <= cw_bit;
            if (!cw_bit) begin
              item_data <= {8'h00, in_byte};
              last_seen <= in_last;
              state     <= PRESENT;
            end else if (in_last) begin
              state <= ERROR;
            end else begin
              item_data[15:8] <= in_byte;
              state           <= ITEM_B1;
            end
          end
        end
        ITEM_B1: begin
          if (accept) begin
            item_data[7:0] <= in_byte;
            last_seen      <= in_last;
            state          <= PRESENT;
          end
        end
        PRESENT: begin
          if (!dec_busy) begin
            state <= HOLDOFF;
          end
        end
        // One idle cycle lets the decompressor raise busy before the next item
        HOLDOFF: begin
          if (last_seen) begin
            last_seen <= 1'b0;
            state     <= CW_LO;
          end else if (item_idx == LAST_IDX) begin
            state <= CW_LO;
          end else begin
            item_idx <= item_idx + 4'd1;
            state    <= ITEM_B0;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= CW_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzrw1_item_unpacker.sv
// Directed and randomized checks of lzrw1_item_unpacker against a stream-level model
// that builds expected items directly from the generated control words and bytes.
module tb_lzrw1_item_unpacker;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] item_data;
  logic        item_flag;
  logic        item_valid;
  logic        dec_busy;
  logic        stream_done;
  logic        format_error;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit busy_rand = 1'b0;
  bit gaps      = 1'b0;

  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  stream_q[$];

  lzrw1_item_unpacker #(.ITEMS_PER_GROUP(16), .CW_MSB_FIRST(1'b0)) dut (
    .clock(clock),
    .reset(reset),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .item_data(item_data),
    .item_flag(item_flag),
    .item_valid(item_valid),
    .dec_busy(dec_busy),
    .stream_done(stream_done),
    .format_error(format_error)
  );

  always #5 clock = ~clock;

  // Inputs change just after posedge, so a negedge view predicts the next edge's transfer
  always @(negedge clock) begin
    if (item_valid && !dec_busy) obs_q.push_back({item_flag, item_data});
    if (stream_done) done_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (busy_rand) dec_busy = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic last);
    bit acc = 1'b0;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      in_last  = 1'($urandom);
      step();
    end
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    for (int g = 0; g < 500 && !acc; g++) begin
      @(negedge clock);
      acc = in_ready;
      step();
    end
    if (!acc) check_output("byte_accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic add_cw(input logic [15:0] w);
    stream_q.push_back(w[7:0]);
    stream_q.push_back(w[15:8]);
  endtask

  task automatic add_literal(input logic [7:0] b);
    stream_q.push_back(b);
    exp_q.push_back({1'b0, 8'h00, b});
  endtask

  task automatic add_copy(input logic [7:0] hi, input logic [7:0] lo);
    stream_q.push_back(hi);
    stream_q.push_back(lo);
    exp_q.push_back({1'b1, hi, lo});
  endtask

  task automatic run_stream(input string tag);
    int base_obs  = obs_q.size();
    int base_done = done_cnt;
    int g = 0;
    for (int i = 0; i < stream_q.size(); i++)
      apply_stimulus(stream_q[i], i == stream_q.size() - 1);
    while (done_cnt <= base_done && g < 500) begin
      step();
      g++;
    end
    repeat (3) step();
    check_output($sformatf("%s done_count", tag), 32'(done_cnt - base_done), 32'd1);
    check_output($sformatf("%s item_count", tag), 32'(obs_q.size() - base_obs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_obs + i < obs_q.size())
        check_output($sformatf("%s item%0d", tag, i), 32'(obs_q[base_obs + i]), 32'(exp_q[i]));
      else
        check_output($sformatf("%s item%0d missing", tag, i), 32'hdead_beef, 32'(exp_q[i]));
    end
    check_output($sformatf("%s format_error", tag), 32'(format_error), 32'd0);
    stream_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_output($sformatf("%s in_ready", tag), 32'(in_ready), 32'd0);
    check_output($sformatf("%s item_valid", tag), 32'(item_valid), 32'd0);
    check_output($sformatf("%s item_data", tag), 32'(item_data), 32'd0);
    check_output($sformatf("%s item_flag", tag), 32'(item_flag), 32'd0);
    check_output($sformatf("%s stream_done", tag), 32'(stream_done), 32'd0);
    check_output($sformatf("%s format_error", tag), 32'(format_error), 32'd0);
  endtask

  initial begin
    int base_obs;
    int base_done;
    logic [15:0] cw;
    int k;
    int n;

    reset    = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    dec_busy = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    step();
    check_output("post_reset in_ready", 32'(in_ready), 32'd1);

    // Two literals then end of stream
    add_cw(16'h0000); add_literal(8'h41); add_literal(8'h42);
    run_stream("two_literals");

    // Literal then copy
    add_cw(16'h0002); add_literal(8'h78); add_copy(8'h12, 8'h34);
    run_stream("lit_copy");

    // Decompressor holds busy for ten cycles on item 0x0041
    dec_busy  = 1'b1;
    base_obs  = obs_q.size();
    base_done = done_cnt;
    apply_stimulus(8'h00, 1'b0);
    apply_stimulus(8'h00, 1'b0);
    apply_stimulus(8'h41, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check_output($sformatf("stall%0d item_valid", c), 32'(item_valid), 32'd1);
      check_output($sformatf("stall%0d item_data", c), 32'(item_data), 32'h0041);
      check_output($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
      step();
    end
    check_output("stall no_early_transfer", 32'(obs_q.size() - base_obs), 32'd0);
    dec_busy = 1'b0;
    step();
    check_output("stall transfer_count", 32'(obs_q.size() - base_obs), 32'd1);
    @(negedge clock);
    check_output("stall holdoff item_valid", 32'(item_valid), 32'd0);
    if (obs_q.size() > base_obs)
      check_output("stall item", 32'(obs_q[base_obs]), 32'h0_0041);
    step();
    exp_q.push_back(17'h0_0042);
    stream_q.push_back(8'h42);
    apply_stimulus(8'h42, 1'b1);
    stream_q.delete();
    repeat (4) step();
    check_output("stall done_count", 32'(done_cnt - base_done), 32'd1);
    check_output("stall second_item_count", 32'(obs_q.size() - base_obs), 32'd2);
    if (obs_q.size() > base_obs + 1)
      check_output("stall second_item", 32'(obs_q[base_obs + 1]), 32'(exp_q[0]));
    exp_q.delete();

    // Full group of sixteen literals, then a fresh control word with one copy
    add_cw(16'h0000);
    for (int i = 1; i <= 16; i++) add_literal(8'(i));
    add_cw(16'hFFFF); add_copy(8'hAA, 8'hBB);
    run_stream("group_boundary");

    // Random streams with random stalls and input gaps
    busy_rand = 1'b1;
    gaps      = 1'b1;
    for (int s = 0; s < 8; s++) begin
      k = $urandom_range(1, 40);
      n = 0;
      while (n < k) begin
        cw = 16'($urandom);
        add_cw(cw);
        for (int i = 0; i < 16 && n < k; i++) begin
          if (cw[i]) add_copy(8'($urandom), 8'($urandom));
          else add_literal(8'($urandom));
          n++;
        end
      end
      run_stream($sformatf("random%0d", s));
    end
    busy_rand = 1'b0;
    gaps      = 1'b0;
    dec_busy  = 1'b0;

    // Stream ends on the first byte of a copy
    base_obs  = obs_q.size();
    base_done = done_cnt;
    apply_stimulus(8'h01, 1'b0);
    apply_stimulus(8'h00, 1'b0);
    apply_stimulus(8'h55, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check_output($sformatf("error%0d format_error", c), 32'(format_error), 32'd1);
      check_output($sformatf("error%0d in_ready", c), 32'(in_ready), 32'd0);
      check_output($sformatf("error%0d item_valid", c), 32'(item_valid), 32'd0);
      step();
    end
    check_output("error no_items", 32'(obs_q.size() - base_obs), 32'd0);
    check_output("error no_done", 32'(done_cnt - base_done), 32'd0);

    reset = 1'b0;
    #1;
    check_all_zero("error_reset");
    step();
    reset = 1'b1;
    step();

    // Reset while the second byte of a copy is pending
    apply_stimulus(8'h01, 1'b0);
    apply_stimulus(8'h00, 1'b0);
    apply_stimulus(8'h55, 1'b0);
    reset = 1'b0;
    #1;
    check_all_zero("mid_item_reset");
    step();
    check_all_zero("mid_item_reset_hold");
    reset = 1'b1;
    step();
    add_cw(16'h0000); add_literal(8'h61);
    run_stream("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
